// File: rtl/aes_inv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_pkg
// Description : Shared types and constants for the serial AES-128 decryptor:
//               step encoding, zero-key round-key table, GF(2^8) helpers.
// Revision    : 1.0  initial release
// ============================================================================
package aes_inv_pkg;

  // Sequencer step: IDLE, one InvShiftRows cycle, 16 InvSBox rotations, ARK.
  typedef enum logic [4:0] {
    STEP_IDLE = 5'd0,
    STEP_ISR  = 5'd1,
    STEP_SB0  = 5'd2,
    STEP_SB1  = 5'd3,
    STEP_SB2  = 5'd4,
    STEP_SB3  = 5'd5,
    STEP_SB4  = 5'd6,
    STEP_SB5  = 5'd7,
    STEP_SB6  = 5'd8,
    STEP_SB7  = 5'd9,
    STEP_SB8  = 5'd10,
    STEP_SB9  = 5'd11,
    STEP_SB10 = 5'd12,
    STEP_SB11 = 5'd13,
    STEP_SB12 = 5'd14,
    STEP_SB13 = 5'd15,
    STEP_SB14 = 5'd16,
    STEP_SB15 = 5'd17,
    STEP_ARK  = 5'd18
  } step_t;

  // Round keys K0..K10 of the all-zero cipher key (same table as the encryptor).
  function automatic logic [127:0] round_key(input logic [3:0] idx);
    case (idx)
      4'd0:    return 128'h00000000_00000000_00000000_00000000;
      4'd1:    return 128'h62636363_62636363_62636363_62636363;
      4'd2:    return 128'h9B9898C9_F9FBFBAA_9B9898C9_F9FBFBAA;
      4'd3:    return 128'h90973450_696CCFFA_F2F45733_0B0FAC99;
      4'd4:    return 128'hEE06DA7B_876A1581_759E42B2_7E91EE2B;
      4'd5:    return 128'h7F2E2B88_F8443E09_8DDA7CBB_F34B9290;
      4'd6:    return 128'hEC614B85_1425758C_99FF0937_6AB49BA7;
      4'd7:    return 128'h21751787_3550620B_ACAF6B3C_C61BF09B;
      4'd8:    return 128'h0EF90333_3BA96138_97060A04_511DFA9F;
      4'd9:    return 128'hB1D4D8E2_8A7DB9DA_1D7BB3DE_4C664941;
      4'd10:   return 128'hB4EF5BCB_3E92E211_23E951CF_6F8F188E;
      default: return 'x;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_mix_columns_ref.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_mix_columns_ref
// Description : Combinational AES InvMixColumns over a full 128-bit state,
//               FIPS-197 byte 0 at [127:120], column-major.
// Revision    : 1.0  initial release
// ============================================================================
module aes_inv_mix_columns_ref
  import aes_inv_pkg::*;
(
  input  logic [127:0] i_dat,
  output logic [127:0] o_dat
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_dat[127 - 32*c -: 8];
    assign w_a1 = i_dat[119 - 32*c -: 8];
    assign w_a2 = i_dat[111 - 32*c -: 8];
    assign w_a3 = i_dat[103 - 32*c -: 8];

    assign o_dat[127 - 32*c -: 8] = gf_mul(w_a0, 8'h0E) ^ gf_mul(w_a1, 8'h0B) ^
                                    gf_mul(w_a2, 8'h0D) ^ gf_mul(w_a3, 8'h09);
    assign o_dat[119 - 32*c -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0E) ^
                                    gf_mul(w_a2, 8'h0B) ^ gf_mul(w_a3, 8'h0D);
    assign o_dat[111 - 32*c -: 8] = gf_mul(w_a0, 8'h0D) ^ gf_mul(w_a1, 8'h09) ^
                                    gf_mul(w_a2, 8'h0E) ^ gf_mul(w_a3, 8'h0B);
    assign o_dat[103 - 32*c -: 8] = gf_mul(w_a0, 8'h0B) ^ gf_mul(w_a1, 8'h0D) ^
                                    gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0E);
  end

endmodule
`default_nettype wire

// File: rtl/aes_sbox_canright.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_canright
// Description : Combinational AES S-box / inverse S-box. Field inversion is
//               computed as x^254; i_decrypt selects the inverse direction.
// Revision    : 1.0  initial release
// ============================================================================
module aes_sbox_canright
  import aes_inv_pkg::*;
(
  input  logic [7:0] i_dat,
  input  logic       i_decrypt,
  output logic [7:0] o_dat
);

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // x^254 = x^-1 for x != 0, and 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
  endfunction

  // Forward: affine(inverse(x)); inverse: inverse(inv_affine(x)).
  always_comb begin
    if (i_decrypt) o_dat = gf_inv(inv_affine(i_dat));
    else           o_dat = affine(gf_inv(i_dat));
  end

endmodule
`default_nettype wire

// File: rtl/aes_serial_inv_cipher.sv
`default_nettype none
// ============================================================================
// Module      : aes_serial_inv_cipher
// Description : Byte-serial AES-128 decryptor with a fixed all-zero key. One
//               shared InvSBox rotates through the 16 state bytes; each round
//               takes 18 cycles, a block 180 cycles after the accept edge.
// Revision    : 1.0  initial release
// ============================================================================
module aes_serial_inv_cipher
  import aes_inv_pkg::*;
#(
  parameter int NB_ROUNDS = 10  // only 10 is supported (key table is AES-128)
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  input  logic [127:0] i_dat,
  input  logic         i_read,
  output logic         o_input_consumed,
  output logic [127:0] o_dat,
  output logic         o_valid
);

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r) & 3)) -: 8];
      end
    end
    return o;
  endfunction

  step_t        r_step,  w_step_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_consumed, w_consumed_nxt;

  logic [7:0]   w_sbox_out;
  logic [127:0] w_ark;
  logic [127:0] w_imc_out;

  // The InvSBox always looks at the lowest byte; rotation brings each in turn.
  aes_sbox_canright u_sbox (
    .i_dat     (r_state[7:0]),
    .i_decrypt (1'b1),
    .o_dat     (w_sbox_out)
  );

  assign w_ark = r_state ^ round_key(r_round);

  aes_inv_mix_columns_ref u_imc (
    .i_dat (w_ark),
    .o_dat (w_imc_out)
  );

  // State register; async clear leaves no partial result on o_dat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_step     <= STEP_IDLE;
      r_round    <= 4'd10;
      r_state    <= '0;
      r_valid    <= 1'b0;
      r_consumed <= 1'b0;
    end else begin
      r_step     <= w_step_nxt;
      r_round    <= w_round_nxt;
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_consumed <= w_consumed_nxt;
    end
  end

  // Step sequencing and datapath update; inputs are only looked at in IDLE.
  always_comb begin
    w_step_nxt     = r_step;
    w_round_nxt    = r_round;
    w_state_nxt    = r_state;
    w_valid_nxt    = r_valid;
    w_consumed_nxt = 1'b0;
    case (r_step)
      STEP_IDLE: begin
        if (i_valid && (!r_valid || i_read)) begin
          w_state_nxt    = i_dat ^ round_key(4'(NB_ROUNDS));
          w_round_nxt    = 4'(NB_ROUNDS - 1);
          w_valid_nxt    = 1'b0;
          w_consumed_nxt = 1'b1;
          w_step_nxt     = STEP_ISR;
        end else if (i_read) begin
          w_valid_nxt = 1'b0;
        end
      end
      STEP_ISR: begin
        w_state_nxt = inv_shift_rows(r_state);
        w_step_nxt  = STEP_SB0;
      end
      STEP_ARK: begin
        if (r_round != 4'd0) begin
          w_state_nxt = w_imc_out;
          w_round_nxt = r_round - 4'd1;
          w_step_nxt  = STEP_ISR;
        end else begin
          w_state_nxt = w_ark;
          w_valid_nxt = 1'b1;
          w_step_nxt  = STEP_IDLE;
        end
      end
      default: begin
        if (r_step inside {[STEP_SB0:STEP_SB15]}) begin
          // SB15 + 1 is ARK, so a plain increment covers the last rotation too.
          w_state_nxt = {w_sbox_out, r_state[127:8]};
          w_step_nxt  = step_t'(r_step + 5'd1);
        end else begin
          w_step_nxt = STEP_IDLE;
        end
      end
    endcase
  end

  assign o_dat            = r_state;
  assign o_valid          = r_valid;
  assign o_input_consumed = r_consumed;

endmodule
`default_nettype wire

// File: tb/tb_aes_serial_inv_cipher.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_serial_inv_cipher
// Description : Self-checking bench for the serial AES-128 decryptor. A
//               behavioural AES-128 encryptor (zero key) produces ciphertexts
//               whose plaintexts the DUT must recover.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_serial_inv_cipher;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic         i_valid;
  logic [127:0] i_dat;
  logic         i_read;
  logic         o_input_consumed;
  logic [127:0] o_dat;
  logic         o_valid;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] C_KAT_CT = 128'h66E94BD4_EF8A2C3B_884CFA59_CA342B2E;

  aes_serial_inv_cipher #(.NB_ROUNDS(10)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_valid          (i_valid),
    .i_dat            (i_dat),
    .i_read           (i_read),
    .o_input_consumed (o_input_consumed),
    .o_dat            (o_dat),
    .o_valid          (o_valid)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: plain AES-128 encryption ---------------
  logic [7:0]   sbox [256];
  logic [127:0] rk   [11];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_model();
    logic [7:0]  p, q, x, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'h0;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[v[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          t[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
      end
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = t[i];
      v = v ^ rk[rnd];
    end
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------------------------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge just after the accept edge (edge 1).
  task automatic wait_result(input logic [127:0] pt, input bit toggle, input bit drop_chk,
                             input string name);
    int cyc;
    int extra;
    cyc   = 1;
    extra = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (o_input_consumed) extra++;
      if (o_valid || cyc >= 400) break;
      if (toggle) begin
        i_valid = 1'($urandom);
        i_dat   = rand128();
      end
    end
    i_valid = 1'b0;
    check({name, " latency"},  128'(cyc), 128'd181);
    check({name, " data"},     o_dat, pt);
    check({name, " extra_consumed"}, 128'(extra), 128'd0);
    if (drop_chk) begin
      @(negedge i_clk);
      check({name, " valid_drop"}, 128'(o_valid), 128'd0);
    end
  endtask

  task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input bit toggle,
                          input bit drop_chk, input string name);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_dat   = ct;
    i_read  = 1'b1;
    @(negedge i_clk);
    check({name, " consumed"}, 128'(o_input_consumed), 128'd1);
    i_valid = 1'b0;
    i_dat   = rand128();
    wait_result(pt, toggle, drop_chk, name);
  endtask

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [127:0] pa, pb, pt;
    build_model();
    tbl[0].ct = C_KAT_CT;
    tbl[0].pt = 128'h0;
    for (int i = 1; i < 8; i++) begin
      tbl[i].pt = (i == 1) ? {128{1'b1}} : rand128();
      tbl[i].ct = aes_enc(tbl[i].pt);
    end

    // Reset state
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_read    = 1'b0;
    i_dat     = '0;
    #12;
    check("reset o_valid",    128'(o_valid), 128'd0);
    check("reset o_dat",      o_dat, 128'd0);
    check("reset o_consumed", 128'(o_input_consumed), 128'd0);
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check("idle o_valid", 128'(o_valid), 128'd0);

    // Table vectors, i_read held high
    for (int i = 0; i < 8; i++) do_block(tbl[i].ct, tbl[i].pt, 1'b0, 1'b1, $sformatf("vec%0d", i));

    // Inputs toggling while busy must be ignored
    pt = rand128();
    do_block(aes_enc(pt), pt, 1'b1, 1'b1, "busy_toggle");

    // Back-pressure: hold result 50 cycles with a second block pending
    pa = rand128();
    pb = rand128();
    @(negedge i_clk);
    i_valid = 1'b1;
    i_dat   = aes_enc(pa);
    i_read  = 1'b1;
    @(negedge i_clk);
    check("bp consumed_a", 128'(o_input_consumed), 128'd1);
    i_dat  = aes_enc(pb);
    i_read = 1'b0;
    wait_result(pa, 1'b0, 1'b0, "bp_a");
    i_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      check("bp hold valid",    128'(o_valid), 128'd1);
      check("bp hold data",     o_dat, pa);
      check("bp hold consumed", 128'(o_input_consumed), 128'd0);
    end
    i_read = 1'b1;
    @(negedge i_clk);
    check("bp consumed_b", 128'(o_input_consumed), 128'd1);
    check("bp valid_fall", 128'(o_valid), 128'd0);
    i_valid = 1'b0;
    wait_result(pb, 1'b0, 1'b1, "bp_b");

    // Reset mid-operation at SB7 of round 5 (81 edges after accept)
    @(negedge i_clk);
    i_valid = 1'b1;
    i_dat   = C_KAT_CT;
    i_read  = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (80) @(negedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("midrst o_valid", 128'(o_valid), 128'd0);
    check("midrst o_dat",   o_dat, 128'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("midrst idle o_valid", 128'(o_valid), 128'd0);
    do_block(C_KAT_CT, 128'h0, 1'b0, 1'b1, "after_rst_kat");

    // Round trip: 200 random blocks
    for (int i = 0; i < 200; i++) begin
      pt = rand128();
      do_block(aes_enc(pt), pt, 1'b0, 1'b0, $sformatf("rt%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
